// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the register file's single write port.
// The winning request is registered onto RegWrite/WriteRegNo/WriteData one cycle after its handshake.
module regfile_wb_arbiter #(
  parameter int NREQ = 4,
  localparam int GW = $clog2(NREQ)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*5-1:0] req_addr,
  input  logic [NREQ*32-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              RegWrite,
  output logic [4:0]        WriteRegNo,
  output logic [31:0]       WriteData,
  output logic [GW-1:0]     grant_id,
  output logic [7:0]        busy_cnt
);

  logic [GW-1:0] last_grant;
  logic [GW-1:0] win_idx;
  logic [GW-1:0] cand;
  logic          win_found;
  logic [4:0]    sel_addr;
  logic [31:0]   sel_data;

  // Scan starting just after the previous winner so every requester gets a turn.
  always_comb begin
    req_ready = '0;
    win_idx   = '0;
    win_found = 1'b0;
    cand      = '0;
    if (!stall) begin
      for (int k = 1; k <= NREQ; k++) begin
        cand = GW'((int'(last_grant) + k) % NREQ);
        if (!win_found && req_valid[cand]) begin
          win_found = 1'b1;
          win_idx   = cand;
        end
      end
    end
    if (win_found) req_ready[win_idx] = 1'b1;
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        sel_addr = req_addr[i*5 +: 5];
        sel_data = req_data[i*32 +: 32];
      end
    end
  end

  // Address, data and grant_id hold between transfers; only RegWrite pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      RegWrite   <= 1'b0;
      WriteRegNo <= '0;
      WriteData  <= '0;
      grant_id   <= '0;
      last_grant <= GW'(NREQ - 1);
    end else if (win_found) begin
      RegWrite   <= 1'b1;
      WriteRegNo <= sel_addr;
      WriteData  <= sel_data;
      grant_id   <= win_idx;
      last_grant <= win_idx;
    end else begin
      RegWrite   <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_cnt <= '0;
    end else if (win_found || (req_valid == '0)) begin
      busy_cnt <= '0;
    end else if (busy_cnt != 8'hFF) begin
      busy_cnt <= busy_cnt + 8'd1;
    end
  end

endmodule
